// File: rtl/serial_logic_datapath.sv
// Two N-bit shift registers A and B. Each shift step computes one bit from their LSBs
// and routes the result back in at the MSB; Op_Done pulses after every N shifts.
module serial_logic_datapath #(
    parameter int N = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Ld_A,
    input  logic         Ld_B,
    input  logic         Shift_En,
    input  logic [N-1:0] Din,
    input  logic [2:0]   F,
    input  logic [1:0]   R,
    output logic [N-1:0] A_out,
    output logic [N-1:0] B_out,
    output logic         Op_Done
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [N-1:0]  a_q, a_d, b_q, b_d;
    logic [2:0]    f_q, f_d;
    logic [1:0]    r_q, r_d;
    logic          run_active_q, run_active_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    logic       load, shift;
    logic [2:0] f_sel;
    logic [1:0] r_sel;
    logic       a0, b0, f_bit, a_in, b_in;

    assign load  = Ld_A | Ld_B;
    assign shift = Shift_En & ~load;
    assign a0    = a_q[0];
    assign b0    = b_q[0];

    // The first step of a run uses the live switches; later steps use the captured copy.
    assign f_sel = run_active_q ? f_q : F;
    assign r_sel = run_active_q ? r_q : R;

    always_comb begin
        f_bit = 1'b0;
        case (f_sel)
            3'b000:  f_bit = a0 & b0;
            3'b001:  f_bit = a0 | b0;
            3'b010:  f_bit = a0 ^ b0;
            3'b011:  f_bit = 1'b1;
            3'b100:  f_bit = ~(a0 & b0);
            3'b101:  f_bit = ~(a0 | b0);
            3'b110:  f_bit = ~(a0 ^ b0);
            default: f_bit = 1'b0;
        endcase
    end

    always_comb begin
        a_in = a0;
        b_in = b0;
        case (r_sel)
            2'b00:   begin a_in = a0;    b_in = b0;    end
            2'b01:   begin a_in = a0;    b_in = f_bit; end
            2'b10:   begin a_in = f_bit; b_in = b0;    end
            default: begin a_in = b0;    b_in = a0;    end
        endcase
    end

    always_comb begin
        a_d          = a_q;
        b_d          = b_q;
        f_d          = f_q;
        r_d          = r_q;
        run_active_d = 1'b0;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        if (load) begin
            if (Ld_A) a_d = Din;
            if (Ld_B) b_d = Din;
            cnt_d = '0;
        end else if (shift) begin
            a_d          = {a_in, a_q[N-1:1]};
            b_d          = {b_in, b_q[N-1:1]};
            run_active_d = 1'b1;
            if (!run_active_q) begin
                f_d = F;
                r_d = R;
            end
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            a_q          <= '0;
            b_q          <= '0;
            f_q          <= '0;
            r_q          <= '0;
            run_active_q <= 1'b0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            a_q          <= a_d;
            b_q          <= b_d;
            f_q          <= f_d;
            r_q          <= r_d;
            run_active_q <= run_active_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
        end
    end

    assign A_out   = a_q;
    assign B_out   = b_q;
    assign Op_Done = done_q;
endmodule

// File: tb/tb_serial_logic_datapath.sv
// Bench for serial_logic_datapath: directed scenarios plus random traffic, all checked
// against a truth-table based reference model of the register pair.
module tb_serial_logic_datapath;
    localparam int N = 4;

    logic         Clk = 1'b0;
    logic         Reset, Ld_A, Ld_B, Shift_En;
    logic [N-1:0] Din;
    logic [2:0]   F;
    logic [1:0]   R;
    logic [N-1:0] A_out, B_out;
    logic         Op_Done;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int ma, mb, mfq, mrq, mcnt;
    bit mrun, mdone;
    int tt [8];

    serial_logic_datapath #(.N(N)) dut (
        .Clk(Clk), .Reset(Reset), .Ld_A(Ld_A), .Ld_B(Ld_B), .Shift_En(Shift_En),
        .Din(Din), .F(F), .R(R), .A_out(A_out), .B_out(B_out), .Op_Done(Op_Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ma = 0; mb = 0; mfq = 0; mrq = 0; mcnt = 0; mrun = 0; mdone = 0;
    endtask

    task automatic model_step(input bit la, input bit lb, input bit sh,
                              input int din, input int f, input int r);
        int fs, rs, a0, b0, fb, ain, bin;
        mdone = 0;
        if (la || lb) begin
            if (la) ma = din;
            if (lb) mb = din;
            mcnt = 0;
            mrun = 0;
        end else if (sh) begin
            fs = mrun ? mfq : f;
            rs = mrun ? mrq : r;
            if (!mrun) begin mfq = f; mrq = r; end
            a0 = ma % 2;
            b0 = mb % 2;
            fb = (tt[fs] >> (a0 * 2 + b0)) % 2;
            case (rs)
                0: begin ain = a0; bin = b0; end
                1: begin ain = a0; bin = fb; end
                2: begin ain = fb; bin = b0; end
                default: begin ain = b0; bin = a0; end
            endcase
            ma = (ma / 2) + ain * (1 << (N - 1));
            mb = (mb / 2) + bin * (1 << (N - 1));
            mcnt++;
            if (mcnt == N) begin mcnt = 0; mdone = 1; end
            mrun = 1;
        end else begin
            mrun = 0;
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".A"}, 32'(A_out), 32'(ma));
        check({tag, ".B"}, 32'(B_out), 32'(mb));
        check({tag, ".done"}, 32'(Op_Done), 32'(mdone));
    endtask

    task automatic step(input bit la, input bit lb, input bit sh,
                        input int din, input int f, input int r, input string tag);
        @(negedge Clk);
        Reset = 0; Ld_A = la; Ld_B = lb; Shift_En = sh;
        Din = N'(din); F = 3'(f); R = 2'(r);
        model_step(la, lb, sh, din, f, r);
        @(posedge Clk);
        #1;
        compare_model(tag);
        $display("%s ld=%0d%0d sh=%0d din=%0h f=%0d r=%0d -> A=%0h B=%0h done=%0d",
                 tag, la, lb, sh, din, f, r, A_out, B_out, Op_Done);
    endtask

    task automatic do_reset(input string tag);
        @(negedge Clk);
        Reset = 1; Ld_A = 0; Ld_B = 0; Shift_En = 1;
        model_reset();
        @(posedge Clk);
        #1;
        compare_model(tag);
        $display("%s reset -> A=%0h B=%0h done=%0d", tag, A_out, B_out, Op_Done);
    endtask

    task automatic load_ab(input int a, input int b, input string tag);
        step(1, 1, 0, a, 0, 0, tag);
        step(0, 1, 0, b, 0, 0, tag);
    endtask

    initial begin
        int exp_a [4];
        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b1111;
        tt[4] = 4'b0111; tt[5] = 4'b0001; tt[6] = 4'b1001; tt[7] = 4'b0000;
        exp_a[0] = 4'b0110; exp_a[1] = 4'b1011; exp_a[2] = 4'b1101; exp_a[3] = 4'b0110;
        Reset = 1; Ld_A = 0; Ld_B = 0; Shift_En = 0; Din = '0; F = '0; R = '0;
        do_reset("reset");
        check("reset.A0", 32'(A_out), 0);

        // XOR through the A router
        load_ab(4'b1100, 4'b1010, "xor");
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0, 3'b010, 2'b10, "xor");
            check("xor.Astep", 32'(A_out), 32'(exp_a[i]));
            check("xor.donestep", 32'(Op_Done), (i == 3) ? 1 : 0);
        end
        check("xor.Bend", 32'(B_out), 4'b1010);
        step(0, 0, 0, 0, 0, 0, "xor_idle");
        check("xor.donepulse", 32'(Op_Done), 0);

        // Swap router
        load_ab(4'b1100, 4'b1010, "swap");
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 3'b101, 2'b11, "swap");
        check("swap.A", 32'(A_out), 4'b1010);
        check("swap.B", 32'(B_out), 4'b1100);

        // Constant 1 into B
        load_ab(4'b1100, 4'b0000, "const");
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 3'b011, 2'b01, "const");
        check("const.A", 32'(A_out), 4'b1100);
        check("const.B", 32'(B_out), 4'b1111);

        // F changes mid-run are ignored
        load_ab(4'b1100, 4'b1010, "capture");
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, (i < 2) ? 3'b010 : 3'b000, 2'b10, "capture");
        check("capture.A", 32'(A_out), 4'b0110);

        // Load aborts a run on its 3rd shift cycle
        load_ab(4'b1100, 4'b1010, "abort");
        step(0, 0, 1, 0, 3'b010, 2'b10, "abort");
        step(0, 0, 1, 0, 3'b010, 2'b10, "abort");
        step(1, 0, 1, 4'b0011, 3'b010, 2'b10, "abort");
        check("abort.A", 32'(A_out), 4'b0011);
        check("abort.B", 32'(B_out), 4'b1010);
        check("abort.done", 32'(Op_Done), 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0, 3'b001, 2'b00, "abort_rerun");
            check("abort.rerun_done", 32'(Op_Done), (i == 3) ? 1 : 0);
        end

        // Reset mid-run, then a full run is needed
        load_ab(4'b1100, 4'b1010, "rstmid");
        step(0, 0, 1, 0, 3'b010, 2'b10, "rstmid");
        step(0, 0, 1, 0, 3'b010, 2'b10, "rstmid");
        do_reset("rstmid");
        check("rstmid.A", 32'(A_out), 0);
        check("rstmid.B", 32'(B_out), 0);
        check("rstmid.done", 32'(Op_Done), 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0, 3'b011, 2'b10, "rstmid_run");
            check("rstmid.run_done", 32'(Op_Done), (i == 3) ? 1 : 0);
        end

        // Held Shift_En pulses every N shifts, pause keeps the count
        load_ab(4'b0101, 4'b0011, "hold");
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0, 3'b110, 2'b10, "hold");
            check("hold.done", 32'(Op_Done), (i == 3 || i == 7) ? 1 : 0);
        end
        step(0, 0, 1, 0, 3'b000, 2'b01, "pause");
        step(0, 0, 0, 0, 3'b000, 2'b01, "pause");
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 3'b100, 2'b01, "pause");
            check("pause.done", 32'(Op_Done), (i == 2) ? 1 : 0);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int p;
            p = int'($urandom_range(0, 99));
            if (p < 2) begin
                do_reset("rand");
            end else begin
                step(p < 8, (p >= 6) && (p < 12), $urandom_range(0, 3) != 0,
                     int'($urandom_range(0, (1 << N) - 1)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), "rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_logic_datapath.md
Name: serial_logic_datapath

Overview:
- Downstream datapath of the serial logic processor control FSM.
- Holds two N-bit shift registers, A and B, and applies a selectable bitwise logic function one bit per clock.
- Driven by the control FSM's Ld_A, Ld_B and Shift_En outputs. Switch inputs supply Din, F and R.
- Produces the register contents for the LED/hex display and a completion pulse after each N-bit pass.

Parameters:
N, 4, register width and number of shifts per operation (N >= 2)

Ports:
Clk  in  1  system clock; all state updates on the rising edge
Reset  in  1  synchronous, active-high reset
Ld_A  in  1  load A from Din this cycle
Ld_B  in  1  load B from Din this cycle
Shift_En  in  1  perform one serial compute/shift step this cycle
Din  in  N  parallel load data from switches
F  in  3  logic function select
R  in  2  router select
A_out  out  N  current contents of register A
B_out  out  N  current contents of register B
Op_Done  out  1  one-cycle pulse: N shifts completed

Behaviour:
- Reset, synchronous, active-high: A=0, B=0, F_q=0, R_q=0, run_active=0, shift count=0, Op_Done=0.
- Reset has priority over all other inputs, including mid-run.
- Loads:
  - Ld_A: A <= Din at the next edge. Ld_B: B <= Din. Both asserted together: both load.
  - Any load cycle suppresses shifting of both registers, clears the shift count and clears run_active, even if Shift_En=1.
- Per-bit compute function, taking a0=A[0] and b0=B[0]:
  - 000 AND, 001 OR, 010 XOR, 011 constant 1
  - 100 NAND, 101 NOR, 110 XNOR, 111 constant 0
- Router, producing the serial-in bits a_in and b_in:
  - 00: a_in=a0, b_in=b0 (both rotate)
  - 01: a_in=a0, b_in=f
  - 10: a_in=f, b_in=b0
  - 11: a_in=b0, b_in=a0 (swap)
- Shift step, when Shift_En=1 and no load: A <= {a_in, A[N-1:1]} and B <= {b_in, B[N-1:1]}. This is a right shift, LSB first.
- Select capture:
  - On a shift cycle with run_active=0: F_q<=F, R_q<=R, run_active<=1, and that cycle computes with the live F and R.
  - On later shift cycles with run_active=1: compute with F_q and R_q. Changes on F and R are ignored until the run ends.
  - run_active clears on any cycle with Shift_En=0, or on a load.
- Shift count:
  - ceil(log2 N)-bit counter; increments on each shift step.
  - When a shift occurs with count=N-1: count wraps to 0 and Op_Done=1 for exactly the following cycle.
  - Shift_En held beyond N cycles keeps shifting and pulses Op_Done every N shifts.
  - Shift_En=0 mid-run: count holds and registers hold. The next shift re-captures F and R and continues the count.
- Outputs:
  - A_out and B_out are the register values directly; updates appear one cycle after the load or shift edge.
  - Op_Done is registered.
- Idle, with no load and no shift: all registers hold.

Test Plan:
- Reset mid-run: after 2 shifts, assert Reset for 1 cycle -> A_out=0, B_out=0, Op_Done=0. The next run needs a full 4 shifts before Op_Done.
- XOR, A-router, N=4: load A=1100, B=1010, F=010, R=10, Shift_En for 4 cycles.
  - A steps 0110, 1011, 1101, 0110.
  - B ends at 1010.
  - Op_Done pulses once, the cycle after the 4th shift.
- Swap: A=1100, B=1010, R=11, F=any, 4 shifts -> A=1010, B=1100.
- Constant into B: A=1100, B=0000, F=011, R=01, 4 shifts -> A=1100, B=1111.
- Select capture: XOR run as in the XOR, A-router scenario, with F changed to 000 after the 2nd shift -> final A still 0110.
- Load abort: assert Ld_A with Din=0011 during the 3rd shift cycle.
  - A=0011; B holds its post-2-shift value 1010.
  - No Op_Done.
  - The next 4-shift run completes normally.
